// File: rtl/mips_pkg.sv
// Shared opcode encodings, ID/EX control-vector layout and the NOP word
// used by the MIPS-subset decode stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Bit positions inside the 6-bit control vector handed to EX.
  localparam int CTRL_W        = 6;
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_ALUSRC   = 2;
  localparam int CTRL_REGDST   = 1;
  localparam int CTRL_ALU_OP_R = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/id_hazard_unit.sv
// Combinational load-use and branch-operand hazard detection for the ID stage.
// Register 0 is hard-wired and never creates a dependency.
module id_hazard_unit (
  input  logic       is_beq,
  input  logic       reads_rs,
  input  logic       reads_rt,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       idex_memread,
  input  logic       idex_regwrite,
  input  logic [4:0] idex_dest,
  input  logic       exmem_memread,
  input  logic [4:0] exmem_dest,
  output logic       stall
);

  logic idex_hit;
  logic exmem_hit;
  logic load_use;
  logic branch_haz;

  assign idex_hit  = (idex_dest != 5'd0) &&
                     ((reads_rs && (rs == idex_dest)) || (reads_rt && (rt == idex_dest)));
  assign exmem_hit = (exmem_dest != 5'd0) &&
                     ((rs == exmem_dest) || (rt == exmem_dest));

  assign load_use   = idex_memread && idex_hit;
  // beq compares in ID, so it must also wait for ALU results and for a load still in MEM.
  assign branch_haz = is_beq && ((idex_regwrite && idex_hit) || (exmem_memread && exmem_hit));

  assign stall = load_use || branch_haz;

endmodule

// File: rtl/id_ex_stage.sv
// ID stage: decodes the MIPS subset, resolves beq/j early, raises stall/flush
// towards fetch and owns the ID/EX pipeline register plus event counters.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instruction_in,
  input  logic [PC_W-1:0]   pc_plus4_in,
  output logic [4:0]        rf_rs_addr,
  output logic [4:0]        rf_rt_addr,
  input  logic [DATA_W-1:0] rf_rs_data,
  input  logic [DATA_W-1:0] rf_rt_data,
  input  logic [4:0]        exmem_dest,
  input  logic              exmem_memread,
  output logic              stall_out,
  output logic              flush_out,
  output logic [PC_W-1:0]   pc_redirect,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic [DATA_W-1:0] idex_rs_data,
  output logic [DATA_W-1:0] idex_rt_data,
  output logic [DATA_W-1:0] idex_imm,
  output logic [4:0]        idex_rs,
  output logic [4:0]        idex_rt,
  output logic [4:0]        idex_dest,
  output logic [PC_W-1:0]   idex_pc,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  logic [5:0]        op;
  logic [4:0]        rs, rt, rd;
  logic [DATA_W-1:0] imm_sext;
  logic [CTRL_W-1:0] dec_ctrl;
  logic [4:0]        dec_dest;
  logic              dec_valid;
  logic              reads_rs, reads_rt;
  logic              is_beq, is_j;
  logic              beq_taken;
  logic [PC_W-1:0]   branch_target, jump_target;

  assign op         = instruction_in[31:26];
  assign rs         = instruction_in[25:21];
  assign rt         = instruction_in[20:16];
  assign rd         = instruction_in[15:11];
  assign imm_sext   = {{(DATA_W-16){instruction_in[15]}}, instruction_in[15:0]};
  assign rf_rs_addr = rs;
  assign rf_rt_addr = rt;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    dec_ctrl  = '0;
    dec_dest  = 5'd0;
    dec_valid = 1'b0;
    reads_rs  = 1'b0;
    reads_rt  = 1'b0;
    is_beq    = 1'b0;
    is_j      = 1'b0;
    case (op)
      OP_RTYPE: if (instruction_in != NOP) begin
        dec_ctrl[CTRL_REGWRITE] = 1'b1;
        dec_ctrl[CTRL_REGDST]   = 1'b1;
        dec_ctrl[CTRL_ALU_OP_R] = 1'b1;
        dec_dest  = rd;
        dec_valid = 1'b1;
        reads_rs  = 1'b1;
        reads_rt  = 1'b1;
      end
      OP_LW: begin
        dec_ctrl[CTRL_REGWRITE] = 1'b1;
        dec_ctrl[CTRL_MEMREAD]  = 1'b1;
        dec_ctrl[CTRL_ALUSRC]   = 1'b1;
        dec_dest  = rt;
        dec_valid = 1'b1;
        reads_rs  = 1'b1;
      end
      OP_SW: begin
        dec_ctrl[CTRL_MEMWRITE] = 1'b1;
        dec_ctrl[CTRL_ALUSRC]   = 1'b1;
        dec_valid = 1'b1;
        reads_rs  = 1'b1;
        reads_rt  = 1'b1;
      end
      OP_ADDI: begin
        dec_ctrl[CTRL_REGWRITE] = 1'b1;
        dec_ctrl[CTRL_ALUSRC]   = 1'b1;
        dec_dest  = rt;
        dec_valid = 1'b1;
        reads_rs  = 1'b1;
      end
      OP_BEQ: begin
        is_beq    = 1'b1;
        dec_valid = 1'b1;
        reads_rs  = 1'b1;
        reads_rt  = 1'b1;
      end
      OP_J: begin
        is_j      = 1'b1;
        dec_valid = 1'b1;
      end
      default: ;
    endcase
  end

  id_hazard_unit u_hazard (
    .is_beq        (is_beq),
    .reads_rs      (reads_rs),
    .reads_rt      (reads_rt),
    .rs            (rs),
    .rt            (rt),
    .idex_memread  (idex_ctrl[CTRL_MEMREAD]),
    .idex_regwrite (idex_ctrl[CTRL_REGWRITE]),
    .idex_dest     (idex_dest),
    .exmem_memread (exmem_memread),
    .exmem_dest    (exmem_dest),
    .stall         (stall_out)
  );

  assign beq_taken     = is_beq && (rf_rs_data == rf_rt_data);
  assign branch_target = pc_plus4_in + {instruction_in[PC_W-3:0], 2'b00};
  assign jump_target   = {instruction_in[PC_W-3:0], 2'b00};
  assign flush_out     = !stall_out && (beq_taken || is_j);
  assign pc_redirect   = is_j ? jump_target : branch_target;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idex_ctrl    <= '0;
      idex_rs_data <= '0;
      idex_rt_data <= '0;
      idex_imm     <= '0;
      idex_rs      <= 5'd0;
      idex_rt      <= 5'd0;
      idex_dest    <= 5'd0;
      idex_pc      <= '0;
    end else if (stall_out || !dec_valid) begin
      idex_ctrl    <= '0;
      idex_rs_data <= '0;
      idex_rt_data <= '0;
      idex_imm     <= '0;
      idex_rs      <= 5'd0;
      idex_rt      <= 5'd0;
      idex_dest    <= 5'd0;
      idex_pc      <= '0;
    end else begin
      idex_ctrl    <= dec_ctrl;
      idex_rs_data <= rf_rs_data;
      idex_rt_data <= rf_rt_data;
      idex_imm     <= imm_sext;
      idex_rs      <= rs;
      idex_rt      <= rt;
      idex_dest    <= dec_dest;
      idex_pc      <= pc_plus4_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_out && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (flush_out && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: decode, hazards, branch/jump redirect,
// counter saturation and asynchronous reset.
module tb_id_ex_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction_in;
  logic [7:0]  pc_plus4_in;
  logic [4:0]  rf_rs_addr, rf_rt_addr;
  logic [31:0] rf_rs_data, rf_rt_data;
  logic [4:0]  exmem_dest;
  logic        exmem_memread;
  logic        stall_out, flush_out;
  logic [7:0]  pc_redirect;
  logic [5:0]  idex_ctrl;
  logic [31:0] idex_rs_data, idex_rt_data, idex_imm;
  logic [4:0]  idex_rs, idex_rt, idex_dest;
  logic [7:0]  idex_pc;
  logic [15:0] stall_count, flush_count;

  logic [31:0] rf [32];
  int n_vec = 0;
  int n_err = 0;

  assign rf_rs_data = rf[rf_rs_addr];
  assign rf_rt_data = rf[rf_rt_addr];

  always #5 clock = ~clock;

  id_ex_stage #(.PC_W(8), .DATA_W(32), .CNT_W(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .instruction_in (instruction_in),
    .pc_plus4_in    (pc_plus4_in),
    .rf_rs_addr     (rf_rs_addr),
    .rf_rt_addr     (rf_rt_addr),
    .rf_rs_data     (rf_rs_data),
    .rf_rt_data     (rf_rt_data),
    .exmem_dest     (exmem_dest),
    .exmem_memread  (exmem_memread),
    .stall_out      (stall_out),
    .flush_out      (flush_out),
    .pc_redirect    (pc_redirect),
    .idex_ctrl      (idex_ctrl),
    .idex_rs_data   (idex_rs_data),
    .idex_rt_data   (idex_rt_data),
    .idex_imm       (idex_imm),
    .idex_rs        (idex_rs),
    .idex_rt        (idex_rt),
    .idex_dest      (idex_dest),
    .idex_pc        (idex_pc),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle so registered outputs can be sampled.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a new instruction in ID and let combinational outputs settle.
  task automatic present(input logic [31:0] instr, input logic [7:0] pc4);
    instruction_in = instr;
    pc_plus4_in    = pc4;
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : 32'h100 + i;
    reset          = 1'b1;
    instruction_in = 32'h0;
    pc_plus4_in    = 8'h0;
    exmem_dest     = 5'd0;
    exmem_memread  = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("reset_ctrl",  idex_ctrl, 6'b0);
    check("reset_stall", stall_out, 1'b0);
    check("reset_flush", flush_out, 1'b0);
    check("reset_scnt",  stall_count, 16'd0);

    // add $3,$1,$2
    present(32'h0022_1820, 8'h24);
    check("add_rs_addr", rf_rs_addr, 5'd1);
    check("add_rt_addr", rf_rt_addr, 5'd2);
    check("add_stall",   stall_out, 1'b0);
    tick();
    check("add_ctrl",    idex_ctrl, 6'b100011);
    check("add_dest",    idex_dest, 5'd3);
    check("add_pc",      idex_pc, 8'h24);
    check("add_rsdata",  idex_rs_data, 32'h101);
    check("add_rtdata",  idex_rt_data, 32'h102);
    check("add_imm",     idex_imm, 32'h0000_1820);

    // lw $2,0($1) then add $3,$2,$4
    present(32'h8C22_0000, 8'h28);
    tick();
    check("lw_ctrl",     idex_ctrl, 6'b110100);
    check("lw_dest",     idex_dest, 5'd2);
    present(32'h0044_1820, 8'h2C);
    check("lu_stall",    stall_out, 1'b1);
    check("lu_flush",    flush_out, 1'b0);
    tick();
    check("lu_bubble",   idex_ctrl, 6'b0);
    check("lu_bub_dest", idex_dest, 5'd0);
    check("lu_bub_pc",   idex_pc, 8'h0);
    check("lu_scnt",     stall_count, 16'd1);
    check("lu_release",  stall_out, 1'b0);
    tick();
    check("lu_add_ctrl", idex_ctrl, 6'b100011);
    check("lu_add_rs",   idex_rs, 5'd2);
    check("lu_add_rt",   idex_rt, 5'd4);
    check("lu_scnt2",    stall_count, 16'd1);

    // beq $1,$1,+3 at pc+4 = 0x10
    present(32'h1021_0003, 8'h10);
    check("beq_stall",   stall_out, 1'b0);
    check("beq_flush",   flush_out, 1'b1);
    check("beq_target",  pc_redirect, 8'h1C);
    tick();
    check("beq_fcnt",    flush_count, 16'd1);
    check("beq_ctrl",    idex_ctrl, 6'b0);
    check("beq_imm",     idex_imm, 32'h3);

    // lw $5,0($1) then beq $5,$0,+1: two stall cycles
    present(32'h8C25_0000, 8'h30);
    tick();
    present(32'h10A0_0001, 8'h34);
    check("lb_stall1",   stall_out, 1'b1);
    check("lb_flush1",   flush_out, 1'b0);
    tick();
    check("lb_bubble1",  idex_ctrl, 6'b0);
    check("lb_scnt1",    stall_count, 16'd2);
    exmem_dest    = 5'd5;
    exmem_memread = 1'b1;
    #1;
    check("lb_stall2",   stall_out, 1'b1);
    tick();
    check("lb_scnt2",    stall_count, 16'd3);
    exmem_memread = 1'b0;
    exmem_dest    = 5'd0;
    rf[5]         = 32'd0;
    #1;
    check("lb_resolve",  stall_out, 1'b0);
    check("lb_flush",    flush_out, 1'b1);
    check("lb_target",   pc_redirect, 8'h38);
    tick();
    check("lb_fcnt",     flush_count, 16'd2);

    // j 0x3F
    present(32'h0800_003F, 8'h3C);
    check("j_flush",     flush_out, 1'b1);
    check("j_target",    pc_redirect, 8'hFC);
    tick();
    check("j_fcnt",      flush_count, 16'd3);

    // beq $1,$2 not taken
    present(32'h1022_0002, 8'h40);
    check("bnt_flush",   flush_out, 1'b0);
    check("bnt_stall",   stall_out, 1'b0);
    tick();
    check("bnt_fcnt",    flush_count, 16'd3);

    // unknown opcode and NOP both leave a bubble
    present(32'h3C01_1234, 8'h44);
    check("unk_stall",   stall_out, 1'b0);
    check("unk_flush",   flush_out, 1'b0);
    tick();
    check("unk_ctrl",    idex_ctrl, 6'b0);
    check("unk_pc",      idex_pc, 8'h0);
    present(32'h0000_0000, 8'h48);
    tick();
    check("nop_ctrl",    idex_ctrl, 6'b0);
    check("nop_dest",    idex_dest, 5'd0);

    // Saturation: beq $5,$0 blocked by a load in EX/MEM every cycle
    present(32'h10A0_0001, 8'h4C);
    exmem_dest    = 5'd5;
    exmem_memread = 1'b1;
    #1;
    repeat ((1 << 16) + 3) @(posedge clock);
    #1;
    check("sat_scnt",    stall_count, 16'hFFFF);
    check("sat_fcnt",    flush_count, 16'd3);
    check("sat_stall",   stall_out, 1'b1);

    // Reset in the middle of a load-use stall
    exmem_memread = 1'b0;
    exmem_dest    = 5'd0;
    present(32'h8C22_0000, 8'h50);
    tick();
    present(32'h0044_1820, 8'h54);
    check("rst_pre_stall", stall_out, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check("rst_stall",   stall_out, 1'b0);
    check("rst_ctrl",    idex_ctrl, 6'b0);
    check("rst_dest",    idex_dest, 5'd0);
    check("rst_scnt",    stall_count, 16'd0);
    check("rst_fcnt",    flush_count, 16'd0);
    #1;
    reset = 1'b0;
    #1;
    check("rst_rel_stall", stall_out, 1'b0);
    tick();
    check("rst_rel_ctrl",  idex_ctrl, 6'b100011);
    check("rst_rel_scnt",  stall_count, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
